ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 5000, clk cycles the PS/2 clock line is held low before a request (100 us at 50 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 1000000, clk-cycle limit from request-to-send until ack (20 ms at 50 MHz).
REQ-003 clk  input  1  system clock; the single clock domain.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 tx_start  input  1  one-cycle request to transmit tx_data.
REQ-006 tx_data  input  8  command/data byte for the keyboard.
REQ-007 ps2_clk_in  input  1  sampled level of the PS2CLK inout pad.
REQ-008 ps2_data_in  input  1  sampled level of the PS2DATA inout pad.
REQ-009 ps2_clk_oe  output  1  1 = drive PS2CLK low; 0 = release (high-Z).
REQ-010 ps2_data_oe  output  1  1 = drive PS2DATA low; 0 = release (high-Z).
REQ-011 tx_busy  output  1  high from the cycle after acceptance until return to IDLE.
REQ-012 tx_done  output  1  one-cycle pulse at the end of every transfer, including failed ones.
REQ-013 tx_err  output  1  valid only while tx_done=1; 1 = missing ack or timeout.

Function
REQ-014 ps2_clk_in and ps2_data_in SHALL pass through 2-flop synchronizers; a falling edge is detected as sync_prev=1 and sync=0, one cycle after the second flop.
REQ-015 States SHALL be IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE, DONE.
REQ-016 In IDLE, tx_start=1 SHALL latch tx_data and compute odd parity (parity = ~^tx_data); tx_busy rises the next cycle.
REQ-017 tx_start SHALL be ignored while tx_busy=1.
REQ-018 INHIBIT: ps2_clk_oe=1, ps2_data_oe=0 for exactly INHIBIT_CYCLES cycles, then go to REQ.
REQ-019 REQ: ps2_data_oe=1 (start bit 0), ps2_clk_oe=0; the timeout counter starts at 0; the first device falling edge moves to SHIFT.
REQ-020 SHIFT: on device falling edges 1-8, present data bits 0-7 LSB first; on edge 9, present parity; on edge 10, release data (stop bit 1). A bit value of 1 SHALL set ps2_data_oe=0 and a bit value of 0 SHALL set ps2_data_oe=1.
REQ-021 After edge 10, go to ACK. On falling edge 11, synchronized data=0 means ack OK and data=1 means ack missing (err flag set). Then go to WAIT_IDLE.
REQ-022 WAIT_IDLE: wait until both synchronized lines are 1, then go to DONE.
REQ-023 DONE: tx_done=1 for one cycle, tx_err=err flag, then go to IDLE with tx_busy=0 in the same transition.
REQ-024 ps2_clk_oe SHALL be 1 only in INHIBIT; in all other states the clock line is released.
REQ-025 The bit counter SHALL be 4 bits wide, count 0-11 only, and never wrap.
REQ-026 tx_done and tx_err SHALL be 0 in every cycle outside DONE.

Reset
REQ-027 When reset=0, all outputs SHALL be 0 immediately, independent of clk: both lines released, tx_busy=0, tx_done=0, tx_err=0.
REQ-028 When reset=0, the state SHALL be IDLE, and the counters, latched byte and synchronizers SHALL be cleared (synchronizers to 1).
REQ-029 Reset asserted mid-frame SHALL abort the frame without a tx_done pulse.
REQ-030 After reset deasserts, the first accepted tx_start SHALL begin a fresh frame.

Configuration
REQ-031 Macro PS2_TX_TIMEOUT_EN, defined: the counter runs in REQ, SHIFT and ACK. On reaching TIMEOUT_CYCLES it SHALL release both lines, set the err flag and go directly to DONE.
REQ-032 PS2_TX_TIMEOUT_EN undefined: no timeout counter is built and the FSM waits indefinitely for device edges. tx_err SHALL then reflect only a missing ack.

Verification
Bench parameters: INHIBIT_CYCLES=10, TIMEOUT_CYCLES=2000. The device model clocks at 1/40 of clk.
REQ-033 tx_data=0xED with device ack -> clk_oe high exactly 10 cycles; line bits 1,0,1,1,0,1,1,1; parity 1; stop 1; tx_done=1 with tx_err=0.
REQ-034 tx_data=0x01 -> parity bit 0; tx_data=0x00 -> parity bit 1; both complete with tx_err=0.
REQ-035 Device withholds ack (data high at edge 11) -> tx_done=1, tx_err=1; next tx_start accepted.
REQ-036 Device never clocks, with PS2_TX_TIMEOUT_EN defined -> tx_done and tx_err pulse 2000 cycles after REQ entry; both oe=0.
REQ-037 tx_start repeated mid-frame -> ignored; exactly one frame sent.
REQ-038 reset=0 asserted after bit 4 -> both oe=0 asynchronously; no tx_done; a new 0xF4 after reset transmits correctly.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, requests to send, then shifts
// a byte, odd parity and stop bit on device clock edges. Define PS2_TX_TIMEOUT_EN for the abort timer.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err
);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    ACK,
    WAIT_IDLE,
    DONE
  } state_t;

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

  if (INHIBIT_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("ps2_host_tx: cycle parameters must be positive");
  end

  state_t           state, state_next;
  logic [INH_W-1:0] inh_cnt, inh_cnt_next;
  logic [3:0]       bit_cnt, bit_cnt_next;
  logic             data_low, data_low_next;
  logic             err_flag, err_next;
  logic [7:0]       tx_byte, byte_next;
  logic             tx_parity, parity_next;

  logic clk_s1, clk_s2, clk_prev;
  logic data_s1, data_s2;
  logic clk_fall;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt, tmo_next;
`endif

  // Idle-high lines, so the synchronizers reset to 1 to avoid a false edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk_in;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps2_data_in;
      data_s2  <= data_s1;
    end
  end

  assign clk_fall = clk_prev & ~clk_s2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      inh_cnt   <= '0;
      bit_cnt   <= '0;
      data_low  <= 1'b0;
      err_flag  <= 1'b0;
      tx_byte   <= '0;
      tx_parity <= 1'b0;
    end else begin
      state     <= state_next;
      inh_cnt   <= inh_cnt_next;
      bit_cnt   <= bit_cnt_next;
      data_low  <= data_low_next;
      err_flag  <= err_next;
      tx_byte   <= byte_next;
      tx_parity <= parity_next;
    end
  end

`ifdef PS2_TX_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tmo_cnt <= '0;
    else        tmo_cnt <= tmo_next;
  end
`endif

  always_comb begin
    state_next    = state;
    inh_cnt_next  = inh_cnt;
    bit_cnt_next  = bit_cnt;
    data_low_next = data_low;
    err_next      = err_flag;
    byte_next     = tx_byte;
    parity_next   = tx_parity;

    case (state)
      IDLE: begin
        if (tx_start) begin
          byte_next     = tx_data;
          parity_next   = ~^tx_data;
          bit_cnt_next  = '0;
          inh_cnt_next  = '0;
          err_next      = 1'b0;
          data_low_next = 1'b0;
          state_next    = INHIBIT;
        end
      end
      INHIBIT: begin
        if (inh_cnt == INH_LAST) begin
          data_low_next = 1'b1;
          state_next    = REQ;
        end else begin
          inh_cnt_next = inh_cnt + 1'b1;
        end
      end
      REQ: begin
        if (clk_fall) begin
          bit_cnt_next  = 4'd1;
          data_low_next = ~tx_byte[0];
          state_next    = SHIFT;
        end
      end
      // Edge k presents bit k-1, so the old count indexes the next bit to drive
      SHIFT: begin
        if (clk_fall) begin
          bit_cnt_next = bit_cnt + 4'd1;
          if (bit_cnt <= 4'd7) begin
            data_low_next = ~tx_byte[bit_cnt[2:0]];
          end else if (bit_cnt == 4'd8) begin
            data_low_next = ~tx_parity;
          end else begin
            data_low_next = 1'b0;
            state_next    = ACK;
          end
        end
      end
      ACK: begin
        if (clk_fall) begin
          err_next     = data_s2;
          bit_cnt_next = 4'd11;
          state_next   = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (clk_s2 && data_s2) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    // Timer overrides any edge-driven move so a stalled device always ends the frame
    tmo_next = '0;
    if (state == REQ || state == SHIFT || state == ACK) begin
      if (tmo_cnt == TMO_LAST) begin
        data_low_next = 1'b0;
        err_next      = 1'b1;
        state_next    = DONE;
      end else begin
        tmo_next = tmo_cnt + 1'b1;
      end
    end
`endif
  end

  assign ps2_clk_oe  = (state == INHIBIT);
  assign ps2_data_oe = data_low & ((state == REQ) || (state == SHIFT));
  assign tx_busy     = (state != IDLE);
  assign tx_done     = (state == DONE);
  assign tx_err      = (state == DONE) & err_flag;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model clocking at clk/40.
// Timeout sequence is exercised only when PS2_TX_TIMEOUT_EN is defined.
module tb_ps2_host_tx;
  localparam int INH = 10;
  localparam int TMO = 2000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_err;

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .tx_start(tx_start), .tx_data(tx_data),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  int   oe_cnt = 0;
  int   done_cnt = 0;
  int   err_outside = 0;
  logic last_err = 1'b0;

  always @(negedge clk) begin
    if (ps2_clk_oe) oe_cnt++;
    if (tx_done) begin
      done_cnt++;
      last_err = tx_err;
    end
    if (!tx_done && tx_err) err_outside++;
  end

  typedef struct {
    logic [7:0] data;
    bit         ack;
    bit         exp_par;
    bit         exp_err;
  } vec_t;

  vec_t vecs[5];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic waitRequest(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (ps2_data_oe && !ps2_clk_oe) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic runDevice(input bit ack, output logic [7:0] rx, output logic start_b,
                           output logic par, output logic stop_b, output bit ok);
    rx = 8'hxx; start_b = 1'bx; par = 1'bx; stop_b = 1'bx;
    waitRequest(ok);
    if (!ok) return;
    start_b = ps2_data_in;
    repeat (5) @(negedge clk);
    for (int k = 1; k <= 11; k++) begin
      if (k == 11 && ack) begin
        dev_data_low = 1'b1;
        repeat (3) @(negedge clk);
      end
      dev_clk_low = 1'b1;
      repeat (20) @(negedge clk);
      if (k <= 8)       rx[k-1] = ps2_data_in;
      else if (k == 9)  par     = ps2_data_in;
      else if (k == 10) stop_b  = ps2_data_in;
      dev_clk_low = 1'b0;
      repeat (20) @(negedge clk);
      if (k == 11) dev_data_low = 1'b0;
    end
  endtask

  task automatic runFrame(input logic [7:0] d, input bit ack, input bit exp_par,
                          input bit exp_err, input string tag);
    int         done0;
    logic [7:0] rx;
    logic       start_b, par, stop_b;
    bit         ok;
    done0  = done_cnt;
    oe_cnt = 0;
    applyStimulus(d);
    checkOutput({tag, " busy_after_accept"}, 32'(tx_busy), 32'd1);
    runDevice(ack, rx, start_b, par, stop_b, ok);
    checkOutput({tag, " request_seen"}, 32'(ok), 32'd1);
    for (int i = 0; i < 100; i++) begin
      if (done_cnt != done0) break;
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    checkOutput({tag, " inhibit_cycles"}, 32'(oe_cnt), 32'(INH));
    checkOutput({tag, " start_bit"}, 32'(start_b), 32'd0);
    checkOutput({tag, " data_byte"}, 32'(rx), 32'(d));
    checkOutput({tag, " parity"}, 32'(par), 32'(exp_par));
    checkOutput({tag, " stop_bit"}, 32'(stop_b), 32'd1);
    checkOutput({tag, " done_pulses"}, 32'(done_cnt - done0), 32'd1);
    checkOutput({tag, " err"}, 32'(last_err), 32'(exp_err));
    checkOutput({tag, " busy_after_done"}, 32'(tx_busy), 32'd0);
  endtask

  initial begin
    int   done0;
    bit   ok;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", 32'({ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_err}), 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    vecs[0] = '{8'hED, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{8'h01, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h00, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'hA5, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{8'hF4, 1'b1, 1'b0, 1'b0};
    for (int v = 0; v < 5; v++) begin
      runFrame(vecs[v].data, vecs[v].ack, vecs[v].exp_par, vecs[v].exp_err,
               $sformatf("vec%0d", v));
      repeat (5) @(negedge clk);
    end

    // Extra tx_start pulses while a frame is in flight must be ignored
    fork
      runFrame(8'h3C, 1'b1, 1'b1, 1'b0, "midstart");
      begin
        repeat (4) @(negedge clk);
        tx_data = 8'h55; tx_start = 1'b1;
        @(negedge clk) tx_start = 1'b0;
        repeat (200) @(negedge clk);
        tx_start = 1'b1;
        @(negedge clk) tx_start = 1'b0;
      end
    join
    done0  = done_cnt;
    oe_cnt = 0;
    repeat (60) @(negedge clk);
    checkOutput("midstart no_second_frame", 32'(oe_cnt), 32'd0);
    checkOutput("midstart no_extra_done", 32'(done_cnt - done0), 32'd0);

    // Asynchronous reset after four device edges aborts without tx_done
    done0 = done_cnt;
    applyStimulus(8'h77);
    waitRequest(ok);
    checkOutput("abort request_seen", 32'(ok), 32'd1);
    repeat (5) @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      dev_clk_low = 1'b1;
      repeat (20) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (20) @(negedge clk);
    end
    checkOutput("abort data_driven", 32'(ps2_data_oe), 32'd1);
    #2 reset = 1'b0;
    #1 checkOutput("abort async_release", 32'({ps2_clk_oe, ps2_data_oe, tx_busy}), 32'd0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("abort no_done", 32'(done_cnt - done0), 32'd0);
    runFrame(8'hF4, 1'b1, 1'b0, 1'b0, "postreset");

`ifdef PS2_TX_TIMEOUT_EN
    begin
      int n;
      applyStimulus(8'h12);
      waitRequest(ok);
      checkOutput("timeout request_seen", 32'(ok), 32'd1);
      n = 0;
      for (int i = 0; i < TMO + 100; i++) begin
        @(negedge clk);
        n++;
        if (tx_done) break;
      end
      checkOutput("timeout latency", 32'(n), 32'(TMO));
      checkOutput("timeout err", 32'(tx_err), 32'd1);
      checkOutput("timeout lines_released", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
      repeat (5) @(negedge clk);
    end
`endif

    checkOutput("err_outside_done", 32'(err_outside), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
